// File: rtl/button_pkg.sv
// Shared definitions for the button debouncer.
//   state_e                : 2-bit debounce FSM state encoding
//   DefaultCountWidth      : counter width for the 12 MHz defaults
//   DefaultMaxCount        : debounce stability window (about 10 ms at 12 MHz)
//   DefaultLongMaxCount    : hold cycles before a long-press pulse
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int unsigned DefaultCountWidth   = 20;
    localparam int unsigned DefaultMaxCount     = 120000 - 1;
    localparam int unsigned DefaultLongMaxCount = (1 << 20) - 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d_i : asynchronous input
//   q_o : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw pushbutton pin into a clean level plus one-cycle press and
// release pulses, all in the clk domain.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   btn_in        : raw asynchronous button pin
//   pressed       : debounced level, 1 while the button is considered pressed
//   press_pulse   : one-cycle pulse when a press is accepted
//   release_pulse : one-cycle pulse when a release is accepted
//   long_press    : one-cycle pulse after a continuous hold of LONG_MAX_COUNT
// Optional feature macro: BUTTON_DEBOUNCER_LONG_PRESS_EN enables the hold
// counter and long_press; without it long_press is constant 0.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = DefaultCountWidth,
    parameter int unsigned MAX_COUNT      = DefaultMaxCount,
    parameter int unsigned LONG_MAX_COUNT = DefaultLongMaxCount,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    // Both limits must fit the counter so the compare-before-increment never wraps.
    if (64'(MAX_COUNT) >= (64'd1 << COUNT_WIDTH)) begin : g_max_count_check
        $error("MAX_COUNT does not fit in COUNT_WIDTH bits");
    end
    if (64'(LONG_MAX_COUNT) >= (64'd1 << COUNT_WIDTH)) begin : g_long_count_check
        $error("LONG_MAX_COUNT does not fit in COUNT_WIDTH bits");
    end

    localparam logic [COUNT_WIDTH-1:0] MaxCnt = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

    // Synchronizer idles at the released pin level so reset never looks like a press.
    logic pin_sync;
    logic s;

    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (pin_sync)
    );

    // s = 1 means pressed regardless of pin polarity.
    assign s = pin_sync ^ ACTIVE_LOW;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   pressed_q, pressed_d;
    logic                   press_pulse_q, press_pulse_d;
    logic                   release_pulse_q, release_pulse_d;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;

        unique case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == MaxCnt) begin
                    state_d       = PRESSED;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed is silent: the press was never released.
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == MaxCnt) begin
                    state_d         = RELEASED;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase

        // Level follows the accepted state, so it is registered alongside it.
        pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RELEASED;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [COUNT_WIDTH-1:0] LongMaxCnt = COUNT_WIDTH'(LONG_MAX_COUNT);

    logic [COUNT_WIDTH-1:0] hold_q, hold_d;
    logic                   fired_q, fired_d;
    logic                   long_q, long_d;

    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;

        // Only a fresh press restarts the hold; release-wait bounces keep counting.
        if (press_pulse_d) begin
            hold_d = '0;
        end else if (pressed_q && !fired_q) begin
            if (hold_q == LongMaxCnt) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end else begin
                hold_d = hold_q + CntOne;
            end
        end

        if (release_pulse_d) begin
            fired_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    localparam int unsigned MaxCount     = 3;
    localparam int unsigned LongMaxCount = 10;
    // A new level is accepted after this many consecutive edges of disagreement.
    localparam int          AcceptRun    = MaxCount + 2;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .COUNT_WIDTH    (8),
        .MAX_COUNT      (MaxCount),
        .LONG_MAX_COUNT (LongMaxCount),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pin sense delayed two edges, then a run-length rule on
    // how long the sensed level has disagreed with the accepted level.
    bit model_ok = 1'b0;
    bit sense_a, sense_b;
    bit lvl;
    int run;
    bit e_pp, e_rp, e_lp;
    int age;
    bit fired;
    bit s_now, was_lvl;

    always @(posedge clk) begin
        if (rst) begin
            sense_a  = 1'b0;
            sense_b  = 1'b0;
            lvl      = 1'b0;
            run      = 0;
            e_pp     = 1'b0;
            e_rp     = 1'b0;
            e_lp     = 1'b0;
            age      = 0;
            fired    = 1'b0;
            model_ok = 1'b1;
        end else begin
            s_now   = sense_b;
            was_lvl = lvl;
            sense_b = sense_a;
            sense_a = (btn_in == 1'b0);
            e_pp    = 1'b0;
            e_rp    = 1'b0;
            e_lp    = 1'b0;
            if (s_now != lvl) run++;
            else run = 0;
            if (run == AcceptRun) begin
                lvl = s_now;
                run = 0;
                if (s_now) begin
                    e_pp = 1'b1;
                    age  = 0;
                end else begin
                    e_rp = 1'b1;
                end
            end
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
            if (was_lvl && !e_pp && !fired) begin
                age++;
                if (age == LongMaxCount + 1) begin
                    e_lp  = 1'b1;
                    fired = 1'b1;
                end
            end
            if (e_rp) fired = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cycle pressed", {31'd0, pressed}, {31'd0, lvl});
            check("cycle press_pulse", {31'd0, press_pulse}, {31'd0, e_pp});
            check("cycle release_pulse", {31'd0, release_pulse}, {31'd0, e_rp});
            check("cycle long_press", {31'd0, long_press}, {31'd0, e_lp});
        end
    end

    // Edge 0 is the first posedge after the call; records edges 1..n at +1.
    task automatic watch(input int n, output int f_pp, output int n_pp, output int f_rp,
                         output int n_rp, output int f_lp, output int n_lp, output int n_prs);
        f_pp = -1; n_pp = 0; f_rp = -1; n_rp = 0; f_lp = -1; n_lp = 0; n_prs = 0;
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (press_pulse === 1'b1) begin n_pp++; if (f_pp < 0) f_pp = k; end
            if (release_pulse === 1'b1) begin n_rp++; if (f_rp < 0) f_rp = k; end
            if (long_press === 1'b1) begin n_lp++; if (f_lp < 0) f_lp = k; end
            if (pressed === 1'b1) n_prs++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs;
        int tpp, trp, tprs;

        rst    = 1'b1;
        btn_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset pressed", {31'd0, pressed}, 0);
        check("reset press_pulse", {31'd0, press_pulse}, 0);
        check("reset release_pulse", {31'd0, release_pulse}, 0);
        check("reset long_press", {31'd0, long_press}, 0);
        rst = 1'b0;
        watch(20, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("idle press pulses", n_pp, 0);
        check("idle release pulses", n_rp, 0);

        // Clean press and release.
        btn_in = 1'b0;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("press pulse edge", f_pp, 6);
        check("press pulse count", n_pp, 1);
        check("press level", {31'd0, pressed}, 1);
        check("press level cycles", n_prs, 3);
        btn_in = 1'b1;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("release pulse edge", f_rp, 6);
        check("release pulse count", n_rp, 1);
        check("release level", {31'd0, pressed}, 0);
        check("release spurious press", n_pp, 0);

        // Bounce: 2-cycle toggles, then settle pressed.
        tpp = 0;
        trp = 0;
        for (int i = 0; i < 20; i++) begin
            btn_in = ((i / 2) % 2) != 0;
            @(posedge clk);
            #1;
            if (press_pulse === 1'b1) tpp++;
            if (release_pulse === 1'b1) trp++;
        end
        check("bounce press pulses", tpp, 0);
        check("bounce release pulses", trp, 0);
        btn_in = 1'b0;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("bounce settle edge", f_pp, 6);
        check("bounce settle count", n_pp, 1);

        // Release glitch of 3 cycles while pressed.
        btn_in = 1'b1;
        trp  = 0;
        tprs = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (release_pulse === 1'b1) trp++;
            if (pressed === 1'b1) tprs++;
        end
        btn_in = 1'b0;
        watch(10, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("glitch release pulses", trp + n_rp, 0);
        check("glitch pressed cycles", tprs + n_prs, 13);
        btn_in = 1'b1;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("glitch final release edge", f_rp, 6);

        // Reset inside the press wait, pin held pressed.
        btn_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midwait reset pressed", {31'd0, pressed}, 0);
        check("midwait reset press_pulse", {31'd0, press_pulse}, 0);
        rst = 1'b0;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("midwait press edge", f_pp, 6);
        check("midwait press count", n_pp, 1);
        btn_in = 1'b1;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("midwait release edge", f_rp, 6);

        // Long hold.
        btn_in = 1'b0;
        watch(30, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("long hold press edge", f_pp, 6);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        check("long press edge", f_lp, 17);
        check("long press count", n_lp, 1);
`else
        check("long press absent", n_lp, 0);
`endif

        // Reset while held: level drops, then a fresh full debounce.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("held reset pressed", {31'd0, pressed}, 0);
        rst = 1'b0;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("held reset repress edge", f_pp, 6);
        btn_in = 1'b1;
        watch(8, f_pp, n_pp, f_rp, n_rp, f_lp, n_lp, n_prs);
        check("final release edge", f_rp, 6);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw pushbutton pin into a clean, debounced level plus single-cycle press and release pulses, all in the system clock domain. It sits directly upstream of the counter top level and replaces the bare inverted button with a glitch-free signal. Its press pulse can drive a reset or `go` input, and its level can gate LEDs. It contains a two-flop synchronizer, a 4-state debounce FSM and a stability counter.

## Interface

Parameters:
- `COUNT_WIDTH`, default 20: width of the stability counter and the hold counter.
- `MAX_COUNT`, default 120000 - 1: extra cycles a new level must stay stable before it is accepted (about 10 ms at 12 MHz).
- `LONG_MAX_COUNT`, default 2^20 - 1: hold cycles before a long-press pulse. Used only with the long-press feature.
- `ACTIVE_LOW`, default 1: set to 1 when the pin reads 0 while the button is pressed.

Ports:
- `clk`, input, 1 bit: system clock, the only clock in the block.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `btn_in`, input, 1 bit: raw asynchronous button pin.
- `pressed`, output, 1 bit: debounced level, 1 while the button is considered pressed.
- `press_pulse`, output, 1 bit: high for one cycle when a press is accepted.
- `release_pulse`, output, 1 bit: high for one cycle when a release is accepted.
- `long_press`, output, 1 bit: high for one cycle after a continuous hold. Tied to 0 without the long-press feature.

## Operation

- **Synchronizer:** two flops on `btn_in`, reset to the idle pin level (`ACTIVE_LOW`). Their output `s` is polarity-corrected so that `s` = 1 means pressed.
- **States:**
  - `RELEASED`
    - If `s` = 1: go to `PRESS_WAIT` and clear `cnt` to 0.
  - `PRESS_WAIT`
    - If `s` = 0: go to `RELEASED`.
    - Else if `cnt` == `MAX_COUNT`: go to `PRESSED` and assert `press_pulse`.
    - Else: increment `cnt`.
  - `PRESSED`
    - If `s` = 0: go to `RELEASE_WAIT` and clear `cnt` to 0.
  - `RELEASE_WAIT`
    - If `s` = 1: go back to `PRESSED`. No pulse is issued.
    - Else if `cnt` == `MAX_COUNT`: go to `RELEASED` and assert `release_pulse`.
    - Else: increment `cnt`.
- **`pressed` output:** 1 in `PRESSED` and `RELEASE_WAIT`, 0 otherwise. It is registered.
- **Pulse rules:**
  - `press_pulse` and `release_pulse` are registered.
  - They are never high in the same cycle.
  - They can never repeat without an intervening accepted opposite edge.
- **Bounce shorter than `MAX_COUNT` + 1 cycles** gives no output change.
- **Counter width:** `cnt` is `COUNT_WIDTH` bits. The configuration requires `MAX_COUNT` and `LONG_MAX_COUNT` to be less than 2^`COUNT_WIDTH`. `cnt` never wraps, because it is compared before it is incremented.
- **Reset, at any time including mid-wait:**
  - State returns to `RELEASED`.
  - `cnt` and the hold counter clear to 0.
  - Synchronizer flops return to the idle level.
  - All outputs go to 0.
  - A button still held when reset releases is treated as a new press and needs the full debounce.

## Timing

- Reset value of every output is 0.
- Take a clean pin edge sampled at edge 0:
  - `s` changes after edge 1.
  - The wait state is entered after edge 2.
  - `pressed` and `press_pulse` rise after edge `MAX_COUNT` + 3.
- Release has the same latency: `release_pulse` and `pressed` falling occur after edge `MAX_COUNT` + 3.
- Each pulse lasts exactly one cycle.
- Minimum accepted press-to-release spacing is `MAX_COUNT` + 2 cycles.

## Configuration

- Macro: `BUTTON_DEBOUNCER_LONG_PRESS_EN`.
- **Defined:**
  - A hold counter clears when `PRESSED` is entered from `PRESS_WAIT`.
  - While `pressed` = 1 it increments each cycle until it equals `LONG_MAX_COUNT`.
  - In that cycle `long_press` is asserted once, a `fired` flag sets, and counting stops.
  - `fired` clears on `release_pulse` or on reset.
  - `long_press` is high in the cycle after edge `LONG_MAX_COUNT` + 1, counted from the `press_pulse` edge.
  - Bounce that returns `RELEASE_WAIT` to `PRESSED` does not restart the hold counter.
- **Undefined:** no hold counter and no `fired` logic; `long_press` is constant 0.

## Structure

- Shared package `button_pkg` holds:
  - the state encodings `RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT` (2 bits);
  - the default debounce constants for 12 MHz.
- Sub-module `sync_2ff` holds the two-flop synchronizer. Its reset value is given by a parameter.
- The FSM, counters and output registers stay in `button_debouncer`.

## Test plan

All scenarios use `MAX_COUNT` = 3, `LONG_MAX_COUNT` = 10 and `ACTIVE_LOW` = 1.
- **Reset defaults:** hold `rst` for 3 cycles with the pin at 1 → all outputs 0; no pulse appears for 20 cycles after reset.
- **Clean press:** pin 1→0 at edge 0 → `press_pulse` high for exactly one cycle after edge 6, and `pressed` = 1 from then on. Pin 0→1 → `release_pulse` after 6 edges, and `pressed` = 0.
- **Bounce:** the pin toggles 0/1 every 2 cycles for 20 cycles, then stays at 0 → no pulse during the toggling; a single `press_pulse` 6 edges after it settles.
- **Release glitch:** a 3-cycle high glitch while pressed → `pressed` stays 1 and no `release_pulse` occurs.
- **Reset mid-wait:** assert `rst` inside `PRESS_WAIT` with the pin held at 0 → outputs return to 0, then `press_pulse` occurs 6 edges after `rst` deasserts.
- **Long press (macro defined):** hold for 30 cycles → exactly one `long_press`, 11 edges after the `press_pulse` edge. Without the macro, `long_press` stays 0.
